// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int unsigned XLEN_WIDTH       = 32;
  localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four bytes into a little-endian 32-bit word; the word and its
// strobe are presented combinationally in the cycle the 4th byte arrives.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [XLEN_WIDTH-1:0] word_c,
  output logic                  word_valid_c
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_c       = {byte_i, shift_q};
    word_valid_c = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: hunts for a sync byte, reads a word count, then writes
// little-endian words into program memory while holding the core stalled.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [XLEN_WIDTH-1:0] mem_waddr,
  output logic [XLEN_WIDTH-1:0] mem_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [8:0]            words_written
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t         state_q, state_d;
  logic                  we_q, we_d;
  logic [XLEN_WIDTH-1:0] waddr_q, waddr_d;
  logic [XLEN_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      words_q, words_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      count_q, count_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  in_frame_c;
  logic                  tmo_hit_c;
  logic [XLEN_WIDTH-1:0] word_c;
  logic                  word_valid_c;

  assign in_frame_c = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign tmo_hit_c  = in_frame_c && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Packer is held clear outside LEN/DATA, which also discards partial words on abort.
  prog_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (!in_frame_c),
    .byte_valid_i (rx_valid),
    .byte_i       (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    words_d = words_q;
    idx_d   = idx_q;
    count_d = count_q;
    tmo_d   = '0;

    if (in_frame_c && !rx_valid) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          busy_d  = 1'b1;
          words_d = '0;
          idx_d   = '0;
        end
      end
      ST_LEN: begin
        if (tmo_hit_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (word_valid_c) begin
          if (word_c == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (word_c > XLEN_WIDTH'(MAX_WORDS)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
            count_d = word_c[IDX_W-1:0];
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (tmo_hit_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (word_valid_c) begin
          we_d    = 1'b1;
          waddr_d = XLEN_WIDTH'(BASE_ADDR) + XLEN_WIDTH'({idx_q, 2'b00});
          wdata_d = word_c;
          idx_d   = idx_q + IDX_W'(1);
          words_d = words_q + IDX_W'(1);
          if (idx_q == count_q - IDX_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_we        = we_q;
  assign mem_waddr     = waddr_q;
  assign mem_wdata     = wdata_q;
  assign load_busy     = busy_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_written = words_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time controller that fills the instruction RAM from a byte stream, typically the UART receiver.
- Hunts for a sync byte, reads a 32-bit little-endian word count, then assembles little-endian 32-bit words.
- Drives the program memory write port (write_enable / write_address / write_data), one word per write.
- Holds the core stalled via load_busy while loading, and reports completion or abort.

Parameters:
- MAX_WORDS, 256: program memory depth in words; a larger count is rejected.
- BASE_ADDR, 0: byte address of the first word written; must be 4-aligned.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1000000: maximum idle gap between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- mem_we  out  1  program memory write_enable.
- mem_waddr  out  XLEN_WIDTH  program memory write_address (byte address).
- mem_wdata  out  XLEN_WIDTH  program memory write_data.
- load_busy  out  1  high while a frame is in progress; core held stalled.
- load_done  out  1  one-cycle pulse, frame written successfully.
- load_err  out  1  one-cycle pulse, frame aborted.
- words_written  out  9  count of words written in the current or last frame.

Behaviour:
- Reset (synchronous, active-high): state IDLE; mem_we, load_busy, load_done, load_err all 0; mem_waddr, mem_wdata, words_written 0.
- All outputs are registered.
- States: IDLE, LEN, DATA, DONE.
- IDLE:
  - Bytes not equal to SYNC_BYTE are ignored.
  - A SYNC_BYTE with rx_valid moves to LEN next cycle; load_busy goes to 1 that same next cycle.
  - words_written clears to 0.
- LEN:
  - Collect 4 bytes, first byte = bits [7:0] (little-endian).
  - Cycle after the 4th byte:
    - count 0: go to DONE.
    - count > MAX_WORDS: pulse load_err, go to IDLE, no writes issued.
    - otherwise: go to DATA with index 0.
- DATA:
  - Collect 4 bytes per word, little-endian.
  - Cycle after the 4th byte: mem_we=1 for exactly one cycle, mem_waddr=BASE_ADDR+4*index, mem_wdata=assembled word.
  - index and words_written increment on that write.
  - Byte capture continues during the write cycle; back-to-back rx_valid on consecutive cycles loses nothing.
  - After the write with index==count-1, go to DONE.
- DONE (one cycle): load_done=1, load_busy=1; next cycle go to IDLE with load_busy=0.
- Timeout:
  - Idle-cycle counter runs in LEN and DATA, clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES: pulse load_err, discard partial word, go to IDLE.
  - Words already written stay in memory.
- A SYNC_BYTE value inside LEN or DATA is treated as plain data.
- rx_valid in the DONE cycle is ignored.
- Reset mid-frame: immediate return to reset values next edge; no write issued that cycle; partial memory contents are not restored.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- Counter widths: byte-in-word 2 bits; index 9 bits (holds 256); timeout counter $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- common package: loader_state_t enum (IDLE, LEN, DATA, DONE); LOADER_SYNC_BYTE constant; XLEN_WIDTH (existing).
- One natural sub-module, byte_packer: 4-byte shift/assemble with a 2-bit counter and a word_valid strobe, reused by both LEN and DATA.
- FSM, address/index counter and timeout counter stay in prog_loader.

Test Plan:
- Sync-only: stream 0x00, 0x13, 0xA5 -> load_busy rises one cycle after 0xA5; no mem_we.
- Three-word frame: A5, 03 00 00 00, then 13 00 00 00, 93 00 10 00, 6F 00 00 00 -> mem_we at addresses 0, 4, 8 with data 0x00000013, 0x00100093, 0x0000006F; load_done pulses once; words_written=3; load_busy drops next cycle.
- Back-to-back bytes on every cycle, two words -> exactly 2 writes, correct data, none dropped.
- Oversize count: A5, 01 01 00 00 (257) -> load_err pulse, zero writes, IDLE.
- Timeout with TIMEOUT_CYCLES=16: A5, 01 00 00 00, 13 00, then silence -> load_err exactly 16 cycles after the last byte; no write.
- Reset asserted after 2 of 3 words written -> all outputs 0 next edge; a fresh frame afterwards loads correctly from BASE_ADDR.
